// File: rtl/ram_burst_pkg.sv
// Shared constants for the burst RAM controller: default geometry and FSM state encodings.
package ram_burst_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO that holds RAM read data until the consumer accepts it.
module rd_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign count_o     = cnt_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Head is always the oldest word; a pop shifts the tail forward.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_d - 2'd1;
    end
    if (push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
        head_d = in_data_i;
      end else begin
        tail_d = in_data_i;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write controller for a single-port RAM with one-cycle read latency.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW:0]      cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             ram_w_en,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out
);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d, addr_inc;
  logic [AW:0]      cnt_q, cnt_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;
  logic             drain_last;
  logic             buf_in_ready, buf_valid;
  logic [WIDTH-1:0] buf_data;
  logic [1:0]       buf_cnt;

  assign addr_inc = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

  // Captures read data exactly one cycle after the access; flushed by reset.
  rd_skid_buf #(.WIDTH(WIDTH)) u_rd_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (inflight_q & buf_in_ready),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (ram_data_out),
    .out_valid_o (buf_valid),
    .out_ready_i (rd_ready & ~rst),
    .out_data_o  (buf_data),
    .count_o     (buf_cnt)
  );

  assign rd_valid = buf_valid & ~rst;
  assign rd_data  = rd_valid ? buf_data : '0;
  assign busy     = (state_q != ST_IDLE) & ~rst;
  assign done     = (done_q | drain_last) & ~rst;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    inflight_d  = 1'b0;
    done_d      = 1'b0;
    drain_last  = 1'b0;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    ram_w_en    = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            cnt_d   = cmd_len;
            state_d = cmd_write ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_w_en    = 1'b1;
          ram_addr    = addr_q;
          ram_data_in = wr_data;
          addr_d      = addr_inc;
          cnt_d       = cnt_q - (AW+1)'(1);
          if (cnt_q == (AW+1)'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        // Never issue more reads than the buffer can absorb.
        if (({1'b0, buf_cnt} + {2'b00, inflight_q}) < 3'd2) begin
          ram_addr   = addr_q;
          inflight_d = 1'b1;
          addr_d     = addr_inc;
          cnt_d      = cnt_q - (AW+1)'(1);
          if (cnt_q == (AW+1)'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (buf_valid && rd_ready && (buf_cnt == 2'd1) && !inflight_q) begin
          state_d    = ST_IDLE;
          drain_last = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      cmd_ready   = 1'b0;
      wr_ready    = 1'b0;
      ram_w_en    = 1'b0;
      ram_addr    = '0;
      ram_data_in = '0;
      drain_last  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl against a behavioural single-port RAM with one-cycle read.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       busy, done, ram_w_en;
  logic [2:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;

  logic [7:0] mem [8];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, cmd_cyc = 0, wr_cnt = 0;
  bit done_beat = 0;
  bit stall_prev = 0;
  logic [7:0] prev_data;
  logic [7:0] rd_q [$];
  int beat_cyc [$];

  always #5 clk = ~clk;

  ram_burst_ctrl #(.DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe handshakes and protocol rules in mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (rd_valid && rd_ready) begin
        rd_q.push_back(rd_data);
        beat_cyc.push_back(cyc);
      end
      if (stall_prev && rd_valid) chk("rd_stable", 32'(rd_data), 32'(prev_data));
      stall_prev = rd_valid && !rd_ready;
      prev_data  = rd_data;
      chk("wen_only_on_beat", 32'(ram_w_en), 32'(wr_valid && wr_ready));
      if (!ram_w_en) chk("data_in_zero", 32'(ram_data_in), 32'd0);
      if (!busy) chk("idle_no_access", 32'({ram_w_en, ram_addr}), 32'd0);
      if (busy) chk("busy_blocks_cmd", 32'(cmd_ready), 32'd0);
      if (ram_w_en) wr_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_beat = rd_valid && rd_ready;
      end
      if (cmd_valid && cmd_ready) cmd_cyc = cyc;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic send_cmd(input logic w, input logic [2:0] a, input logic [3:0] l);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [2:0] a, input logic [3:0] l,
                             input logic [7:0] d [8], input bit gaps);
    int t, d0;
    d0 = done_cnt;
    send_cmd(1'b1, a, l);
    for (int i = 0; i < int'(l); i++) begin
      if (gaps) repeat (i % 3) begin wr_valid = 1'b0; @(posedge clk); #1; end
      wr_valid = 1'b1; wr_data = d[i];
      t = 0;
      @(negedge clk);
      while (!wr_ready && t < 20) begin @(negedge clk); t++; end
      chk("wr_ready", 32'(wr_ready), 32'd1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 20) begin @(posedge clk); #1; t++; end
    repeat (2) begin @(posedge clk); #1; end
    chk("wr_done_once", 32'(done_cnt - d0), 32'd1);
    chk("wr_busy_after", 32'(busy), 32'd0);
  endtask

  task automatic read_burst(input logic [2:0] a, input logic [3:0] l,
                            input logic [7:0] e [8], input bit bp);
    int t, d0, k, mx;
    rd_q.delete(); beat_cyc.delete();
    d0 = done_cnt; rd_ready = 1'b1;
    send_cmd(1'b0, a, l);
    t = 0; k = 0;
    while (done_cnt == d0 && t < 200) begin
      rd_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      @(posedge clk); #1;
      k++; t++;
    end
    rd_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rd_count", 32'(rd_q.size()), 32'(l));
    for (int i = 0; i < int'(l); i++)
      chk("rd_data", (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hFFFF, 32'(e[i]));
    chk("rd_done_once", 32'(done_cnt - d0), 32'd1);
    chk("rd_done_on_beat", 32'(done_beat), 32'd1);
    chk("rd_busy_after", 32'(busy), 32'd0);
    if (!bp) begin
      mx = 0;
      for (int i = 1; i < beat_cyc.size(); i++)
        if (beat_cyc[i] - beat_cyc[i-1] > mx) mx = beat_cyc[i] - beat_cyc[i-1];
      chk("rd_max_gap", 32'(mx <= 2), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d [8];
    int d0, w0, t;

    // Reset behaviour
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wen", 32'(ram_w_en), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Plain write then read back
    d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00};
    write_burst(3'd2, 4'd4, d, 1'b0);
    chk("mem2", 32'(mem[2]), 32'hA1);
    chk("mem5", 32'(mem[5]), 32'hD4);
    read_burst(3'd2, 4'd4, d, 1'b0);

    // Address wrap
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    write_burst(3'd6, 4'd4, d, 1'b0);
    chk("wrap_mem6", 32'(mem[6]), 32'h11);
    chk("wrap_mem7", 32'(mem[7]), 32'h22);
    chk("wrap_mem0", 32'(mem[0]), 32'h33);
    chk("wrap_mem1", 32'(mem[1]), 32'h44);
    read_burst(3'd6, 4'd4, d, 1'b0);

    // Zero-length command
    d0 = done_cnt; w0 = wr_cnt;
    send_cmd(1'b1, 3'd5, 4'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("len0_done_once", 32'(done_cnt - d0), 32'd1);
    chk("len0_done_next", 32'(done_cyc - cmd_cyc), 32'd1);
    chk("len0_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);

    // Full-depth write with wr_valid gaps
    w0 = wr_cnt;
    d = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF, 8'hB0, 8'hC1};
    write_burst(3'd0, 4'd8, d, 1'b1);
    chk("gap_write_count", 32'(wr_cnt - w0), 32'd8);
    for (int i = 0; i < 8; i++) chk("gap_mem", 32'(mem[i]), 32'(d[i]));

    // Full-depth read with backpressure
    read_burst(3'd0, 4'd8, d, 1'b1);

    // Reset in the middle of a read burst
    rd_q.delete();
    d0 = done_cnt; rd_ready = 1'b1;
    send_cmd(1'b0, 3'd3, 4'd6);
    t = 0;
    while (rd_q.size() < 3 && t < 50) begin @(posedge clk); #1; t++; end
    chk("mid_beats", 32'(rd_q.size()), 32'd3);
    chk("mid_beat0", 32'(rd_q[0]), 32'h8D);
    chk("mid_beat2", 32'(rd_q[2]), 32'hAF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wen", 32'(ram_w_en), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_rd_valid_later", 32'(rd_valid), 32'd0);

    d = '{8'h5A, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    read_burst(3'd0, 4'd2, d, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
